// File: rtl/cache_d.sv
// Direct-mapped, write-through / write-allocate data cache with one word per line.
// A miss stalls in RD_MEM/FILL. Writes always finish with a single WR_MEM beat to memory.
module cache_d #(
  parameter  int MEM_WIDTH  = 32,
  parameter  int MEM_DEPTH  = 65536,
  parameter  int num_blocks = 256,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int FULL_WIDTH = $clog2(MEM_WIDTH * MEM_DEPTH / 8),
  localparam int OFFSET     = $clog2(MEM_WIDTH / 8),
  localparam int INDEX      = $clog2(num_blocks),
  localparam int TAG        = FULL_WIDTH - INDEX - OFFSET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FULL_WIDTH-1:0] address,
  input  logic [MEM_WIDTH-1:0]  din,
  input  logic                  rden,
  input  logic                  wren,
  input  logic [MEM_WIDTH-1:0]  mq,
  output logic                  hit_miss,
  output logic [MEM_WIDTH-1:0]  q,
  output logic [MEM_WIDTH-1:0]  mdout,
  output logic                  mrden,
  output logic                  mwren,
  output logic [ADDR_WIDTH-1:0] maddress
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    FILL   = 2'd2,
    WR_MEM = 2'd3
  } state_t;

  state_t state;

  // Request latched at the sampling edge; the word address doubles as the memory address.
  logic [ADDR_WIDTH-1:0] word_r;
  logic [MEM_WIDTH-1:0]  din_r;
  logic                  write_r;

  logic [num_blocks-1:0] valid;
  logic [TAG-1:0]        tag_mem  [num_blocks];
  logic [MEM_WIDTH-1:0]  data_mem [num_blocks];

  logic [INDEX-1:0]      cur_idx;
  logic [TAG-1:0]        cur_tag;
  logic                  cur_hit;
  logic [INDEX-1:0]      idx_r;
  logic [TAG-1:0]        tag_r;

  // The byte offset does not take part in a word-wide cache.
  logic                  unused_offset;

  assign unused_offset = ^address[OFFSET-1:0];

  assign cur_idx = address[OFFSET +: INDEX];
  assign cur_tag = address[OFFSET+INDEX +: TAG];
  assign cur_hit = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  assign idx_r   = word_r[INDEX-1:0];
  assign tag_r   = word_r[INDEX +: TAG];

  // Line write port: a write hit updates in IDLE, and a refill updates at the end of FILL.
  logic                  line_we;
  logic [INDEX-1:0]      line_idx;
  logic [TAG-1:0]        line_tag;
  logic [MEM_WIDTH-1:0]  line_data;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    line_we   = 1'b0;
    line_idx  = idx_r;
    line_tag  = tag_r;
    line_data = din_r;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (wren && cur_hit) begin
            line_we   = 1'b1;
            line_idx  = cur_idx;
            line_tag  = cur_tag;
            line_data = din;
          end
        end
        FILL: begin
          line_we   = 1'b1;
          line_data = write_r ? din_r : mq;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tag/data arrays carry no reset; clearing the valid bits is enough to empty the cache.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      q        <= '0;
      hit_miss <= 1'b0;
      word_r   <= '0;
      din_r    <= '0;
      write_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rden || wren) begin
            word_r   <= address[FULL_WIDTH-1:OFFSET];
            din_r    <= din;
            write_r  <= wren;
            hit_miss <= cur_hit;
            if (!cur_hit)
              state <= RD_MEM;
            else if (wren)
              state <= WR_MEM;
            else
              q <= data_mem[cur_idx];
          end
        end
        RD_MEM: state <= FILL;
        FILL: begin
          valid[idx_r] <= 1'b1;
          if (write_r) begin
            state <= WR_MEM;
          end else begin
            q     <= mq;
            state <= IDLE;
          end
        end
        WR_MEM: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The strobes decode from the state only. The write data and address come from the latched request.
  assign mrden    = (state == RD_MEM);
  assign mwren    = (state == WR_MEM);
  assign mdout    = din_r;
  assign maddress = word_r;

endmodule

// File: tb/tb_cache_d.sv
// Bench for cache_d: a behavioural cache/memory model plus a simple memory with one-cycle read latency.
// It runs directed scenarios and then a randomized request stream.
module tb_cache_d;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] address = '0;
  logic [31:0] din = '0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] mq = '0;
  logic        hit_miss;
  logic [31:0] q;
  logic [31:0] mdout;
  logic        mrden;
  logic        mwren;
  logic [15:0] maddress;

  int total = 0;
  int bad   = 0;

  cache_d dut (
    .clk(clk), .rst(rst), .address(address), .din(din), .rden(rden), .wren(wren),
    .mq(mq), .hit_miss(hit_miss), .q(q), .mdout(mdout), .mrden(mrden),
    .mwren(mwren), .maddress(maddress)
  );

  always #5 clk = ~clk;

  // Backing memory seen by the DUT.
  logic [31:0] mem [65536];
  always @(posedge clk) begin
    if (mwren) mem[maddress] <= mdout;
    if (mrden) mq <= mem[maddress];
  end

  // Reference model: expected memory contents and cache lines, kept as plain arrays.
  logic [31:0] model_mem [65536];
  bit   [255:0] m_valid = '0;
  logic [7:0]  m_tag  [256];
  logic [31:0] m_data [256];
  logic [31:0] m_q = '0;

  task automatic run_req(input logic [17:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input bit noise,
                         output logic oh, output logic [31:0] oq);
    logic [15:0] word;
    logic [7:0]  idx;
    logic [7:0]  tg;
    logic        hit;
    logic        exp_rd;
    logic        exp_wr;
    int          nbusy;
    word = a[17:2];
    idx  = a[9:2];
    tg   = a[17:10];
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    if (wr) begin
      model_mem[word] = d;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = d;
      nbusy = hit ? 1 : 3;
    end else begin
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = model_mem[word];
      end
      m_q   = m_data[idx];
      nbusy = hit ? 0 : 2;
    end

    @(negedge clk);
    address = a; din = d; rden = rd; wren = wr;
    @(negedge clk);
    rden = 1'b0; wren = 1'b0; address = 18'($urandom); din = $urandom;
    oh = hit_miss;
    total++;
    if (hit_miss !== hit) begin
      bad++;
      $display("FAIL hit_miss @%h: got %b expected %b", a, hit_miss, hit);
    end
    for (int i = 0; i < nbusy; i++) begin
      exp_rd = !hit && (i == 0);
      exp_wr = wr && (i == nbusy - 1);
      total++;
      if ({mrden, mwren} !== {exp_rd, exp_wr}) begin
        bad++;
        $display("FAIL strobes @%h cycle %0d: got mrden=%b mwren=%b expected mrden=%b mwren=%b",
                 a, i, mrden, mwren, exp_rd, exp_wr);
      end
      if (exp_rd || exp_wr) begin
        total++;
        if (maddress !== word) begin
          bad++;
          $display("FAIL maddress @%h: got %h expected %h", a, maddress, word);
        end
      end
      if (exp_wr) begin
        total++;
        if (mdout !== d) begin
          bad++;
          $display("FAIL mdout @%h: got %h expected %h", a, mdout, d);
        end
      end
      if (noise) begin
        address = 18'($urandom); din = $urandom; rden = 1'($urandom); wren = 1'($urandom);
      end
      @(negedge clk);
    end
    rden = 1'b0; wren = 1'b0;
    total++;
    if ({mrden, mwren} !== 2'b00) begin
      bad++;
      $display("FAIL idle strobes @%h: got %b%b expected 00", a, mrden, mwren);
    end
    total++;
    if (q !== m_q) begin
      bad++;
      $display("FAIL q @%h: got %h expected %h", a, q, m_q);
    end
    oq = q;
    if (wr) begin
      total++;
      if (mem[word] !== model_mem[word]) begin
        bad++;
        $display("FAIL memory word %h: got %h expected %h", word, mem[word], model_mem[word]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({hit_miss, q, mrden, mwren, mdout, maddress} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got hm=%b q=%h mrden=%b mwren=%b mdout=%h maddr=%h expected all 0",
               hit_miss, q, mrden, mwren, mdout, maddress);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        oh;
    logic [31:0] oq;
    run_req(18'h01000, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b0 || mem[16'h0400] !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL write miss: got hm=%b mem=%h expected 0 aaaaaaaa", oh, mem[16'h0400]);
    end
    run_req(18'h01000, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b1 || oq !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL read hit: got hm=%b q=%h expected 1 aaaaaaaa", oh, oq);
    end
    run_req(18'h01000, 32'hBBBBBBBB, 1'b0, 1'b1, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b1 || mem[16'h0400] !== 32'hBBBBBBBB) begin
      bad++;
      $display("FAIL write hit: got hm=%b mem=%h expected 1 bbbbbbbb", oh, mem[16'h0400]);
    end
    run_req(18'h01400, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b0 || oq !== model_mem[16'h0500]) begin
      bad++;
      $display("FAIL conflict miss: got hm=%b q=%h expected 0 %h", oh, oq, model_mem[16'h0500]);
    end
    run_req(18'h01000, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b0 || oq !== 32'hBBBBBBBB) begin
      bad++;
      $display("FAIL eviction: got hm=%b q=%h expected 0 bbbbbbbb", oh, oq);
    end
  endtask

  task automatic test_both_high();
    logic        oh;
    logic [31:0] oq;
    run_req(18'h02008, 32'h13572468, 1'b1, 1'b1, 1'b0, oh, oq);
    run_req(18'h02008, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b1 || oq !== 32'h13572468) begin
      bad++;
      $display("FAIL both high as write: got hm=%b q=%h expected 1 13572468", oh, oq);
    end
  endtask

  task automatic test_ignored();
    logic        oh;
    logic [31:0] oq;
    run_req(18'h07FFC, 32'h0, 1'b1, 1'b0, 1'b1, oh, oq);
    run_req(18'h04004, 32'hC0FFEE11, 1'b0, 1'b1, 1'b1, oh, oq);
    run_req(18'h04004, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b1 || oq !== 32'hC0FFEE11) begin
      bad++;
      $display("FAIL ignored requests: got hm=%b q=%h expected 1 c0ffee11", oh, oq);
    end
  endtask

  task automatic test_reset_mid();
    logic        oh;
    logic [31:0] oq;
    @(negedge clk);
    address = 18'h03000; rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    total++;
    if (mrden !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid entry: got mrden=%b expected 1", mrden);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({hit_miss, q, mrden, mwren, mdout, maddress} !== '0) begin
      bad++;
      $display("FAIL reset_mid outputs: got hm=%b q=%h mrden=%b mwren=%b mdout=%h maddr=%h expected all 0",
               hit_miss, q, mrden, mwren, mdout, maddress);
    end
    rst = 1'b0;
    m_valid = '0;
    m_q = '0;
    @(negedge clk);
    total++;
    if ({mrden, mwren} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid strobe after reset: got %b%b expected 00", mrden, mwren);
    end
    run_req(18'h01000, 32'h0, 1'b1, 1'b0, 1'b0, oh, oq);
    total++;
    if (oh !== 1'b0 || oq !== 32'hBBBBBBBB) begin
      bad++;
      $display("FAIL read after reset: got hm=%b q=%h expected 0 bbbbbbbb", oh, oq);
    end
  endtask

  task automatic test_random();
    logic        oh;
    logic [31:0] oq;
    logic [17:0] a;
    int          op;
    for (int n = 0; n < 300; n++) begin
      a  = {8'($urandom_range(0, 3) * 37), 8'($urandom_range(0, 3) * 5), 2'($urandom)};
      op = $urandom_range(0, 3);
      run_req(a, $urandom, (op != 1), (op == 1 || op == 2), ($urandom_range(0, 3) == 0), oh, oq);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]       = $urandom;
      model_mem[i] = mem[i];
    end
    test_reset();
    test_directed();
    test_both_high();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/cache_d.md
CACHE_D -- requirements
Module: cache_d

Interface
REQ-001 Parameter MEM_WIDTH, default 32: data word width in bits.
REQ-002 Parameter MEM_DEPTH, default 65536: backing-memory depth in words.
REQ-003 Parameter num_blocks, default 256: number of cache lines, one word each.
REQ-004 Derived widths: ADDR_WIDTH = clog2(MEM_DEPTH) = 16; FULL_WIDTH = clog2(MEM_WIDTH*MEM_DEPTH/8) = 18; OFFSET = clog2(MEM_WIDTH/8) = 2; INDEX = clog2(num_blocks) = 8; TAG = FULL_WIDTH-INDEX-OFFSET = 8.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port address, input, FULL_WIDTH: CPU byte address; fields are offset [1:0], index [9:2] and tag [17:10].
REQ-009 Port din, input, MEM_WIDTH: CPU write data.
REQ-010 Port rden, input, 1: CPU read request.
REQ-011 Port wren, input, 1: CPU write request.
REQ-012 Port mq, input, MEM_WIDTH: memory read data, valid one cycle after mrden is sampled.
REQ-013 Port hit_miss, output, 1: 1 means the last request hit; 0 means it missed.
REQ-014 Port q, output, MEM_WIDTH: CPU read data.
REQ-015 Port mdout, output, MEM_WIDTH: memory write data.
REQ-016 Port mrden, output, 1: memory read strobe.
REQ-017 Port mwren, output, 1: memory write strobe.
REQ-018 Port maddress, output, ADDR_WIDTH: memory word address, equal to the latched address[17:2].

Function
REQ-019 Organisation: direct-mapped cache; per line one valid bit, one TAG field and one data word.
REQ-020 Policy: write-through with write-allocate; no dirty bits; eviction never writes memory.
REQ-021 FSM: 2-bit register named state with encoding IDLE=0, RD_MEM=1, FILL=2, WR_MEM=3; IDLE must be observable as state==0.
REQ-022 Request acceptance: requests are sampled only in IDLE, on a rising edge with rden or wren high.
  - Address, din and operation are latched at that edge.
  - If rden and wren are both high, the write wins.
  - Requests that arrive outside IDLE are ignored.
REQ-023 Hit definition: valid[index] is set and the stored tag equals the address tag; the comparison is combinational on the current address in IDLE.
REQ-024 Read hit: at the sampling edge q <= line data and hit_miss <= 1; state stays IDLE (1-cycle latency).
REQ-025 Write hit:
  - At the sampling edge the line data <= din and hit_miss <= 1.
  - Next state is WR_MEM.
REQ-026 Miss (read or write): at the sampling edge hit_miss <= 0 and the FSM moves to RD_MEM.
REQ-027 RD_MEM: mrden=1 and maddress = latched word address; FSM moves to FILL on the next edge.
REQ-028 FILL: at the edge ending FILL the line is set to valid=1, tag=latched tag and data=mq.
  - Read: q <= mq, then IDLE.
  - Write: line data <= latched din instead of mq, then WR_MEM.
REQ-029 WR_MEM: mwren=1, mdout = latched din and maddress = latched word address for exactly one cycle; then IDLE.
REQ-030 mrden and mwren are decoded from state only; they are never both high; both are 0 in IDLE and FILL.
REQ-031 q changes only on read completion; hit_miss holds its value until the next accepted request.
REQ-032 Latencies, counted in edges from the sampling edge back to IDLE: read hit 0 extra; write hit 1; read miss 2; write miss 3.

Reset
REQ-033 While rst is high at an edge, the following are forced to reset values:
  - state=IDLE.
  - All valid bits=0.
  - q=0, hit_miss=0.
  - mrden=0, mwren=0, mdout=0, maddress=0.
REQ-034 Reset mid-operation aborts the transaction, with no memory strobe in the following cycle.
REQ-035 Tag and data arrays need not be reset.

Verification
REQ-036 Write miss: after reset, write 0x1000 with 0xAAAAAAAA.
  - Required: hit_miss=0.
  - RD_MEM with maddress=0x0400, then FILL.
  - WR_MEM with mwren=1 and mdout=0xAAAAAAAA.
  - Memory word 0x0400 ends as 0xAAAAAAAA.
REQ-037 Read hit: read 0x1000 -> hit_miss=1, q=0xAAAAAAAA one edge later, no mrden.
REQ-038 Write hit: write 0x1000 with 0xBBBBBBBB.
  - Required: hit_miss=1; one WR_MEM cycle with mdout=0xBBBBBBBB.
  - Memory word 0x0400 and the cache line both end as 0xBBBBBBBB.
REQ-039 Conflict miss: read 0x1400 (same index 0, tag 5) -> hit_miss=0, mrden with maddress=0x0500, q = memory word 0x0500; line 0 is replaced.
REQ-040 Eviction: read 0x1000 again -> hit_miss=0, refill from memory, q=0xBBBBBBBB.
REQ-041 Corner cases:
  - Simultaneous rden and wren are treated as a write.
  - A request issued while state≠0 is ignored.
  - rst asserted during RD_MEM returns the FSM to IDLE and a subsequent read of 0x1000 misses.
